// File: rtl/encap_result_uart_tx_pkg.sv
// Shared types and per-parameter-set sizing for the encapsulation result UART path.
// Field width m and error weight t select the C0 length and its 32-bit word count.
package encap_result_uart_tx_pkg;

  localparam int DBITS    = 8;
  localparam int SB_TICK  = 16;
  localparam int C1_WORDS = 8;
  localparam int K_WORDS  = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND,
    ST_XMIT,
    ST_NEXT,
    ST_FIN
  } ctl_state_t;

  typedef enum logic [1:0] {
    SEC_C0,
    SEC_C1,
    SEC_K
  } sec_t;

  function automatic int m_of(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  function automatic int t_of(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      3:       return 128;
      4:       return 119;
      default: return 128;
    endcase
  endfunction

  function automatic int c0_words(input int ps);
    return (m_of(ps) * t_of(ps) + 31) / 32;
  endfunction

endpackage

// File: rtl/encap_result_uart_tx_tx_byte.sv
// 8N1 byte serializer driven by a 16x oversampling tick.
// The line is registered from the next state so it changes with the FSM, glitch free.
module uart_tx_byte
  import encap_result_uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DBITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);

  tx_state_t  state, state_n;
  logic [3:0] s, s_n;
  logic [2:0] n, n_n;
  logic [7:0] b, b_n;
  logic       tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    tx_done = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (tx_start) begin
          state_n = TX_START;
          s_n     = '0;
          b_n     = din;
        end
      end
      TX_START: begin
        if (tick) begin
          if (s == 4'd15) begin
            state_n = TX_DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (s == 4'd15) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == LAST_BIT) state_n = TX_STOP;
            else n_n = n + 3'd1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (s == STOP_LAST) begin
            state_n = TX_IDLE;
            tx_done = 1'b1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
    tx_n = 1'b1;
    if (state_n == TX_START) tx_n = 1'b0;
    else if (state_n == TX_DATA) tx_n = b_n[0];
  end

endmodule

// File: rtl/encap_result_uart_tx.sv
// Reads C0, C1 and K word by word after encapsulation and streams them MSB byte first.
// One memory read per word; each byte waits for the serializer to finish.
module encap_result_uart_tx
  import encap_result_uart_tx_pkg::*;
#(
  parameter  int parameter_set = 1,
  localparam int C0_WORDS      = c0_words(parameter_set),
  localparam int AW            = $clog2(C0_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tick,
  output logic          rd_C0,
  output logic [AW-1:0] C0_addr,
  input  logic [31:0]   C0_out,
  output logic          rd_C1,
  output logic [2:0]    C1_addr,
  input  logic [31:0]   C1_out,
  output logic          rd_K,
  output logic [2:0]    K_addr,
  input  logic [31:0]   K_out,
  output logic          o_uart_tx,
  output logic          busy,
  output logic          done
);

  localparam int WW = (AW > 3) ? AW : 3;
  localparam logic [WW-1:0] C0_LAST = WW'(C0_WORDS - 1);
  localparam logic [WW-1:0] SK_LAST = WW'(C1_WORDS - 1);

  ctl_state_t    state, state_n;
  sec_t          sec, sec_n;
  logic [WW-1:0] word, word_n, last_word;
  logic [1:0]    byte_idx, byte_n;
  logic [31:0]   word_buf, sec_word;
  logic [7:0]    tx_byte;
  logic          start_d, tx_start, tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sec      <= SEC_C0;
      word     <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      start_d  <= 1'b0;
      C0_addr  <= '0;
      C1_addr  <= '0;
      K_addr   <= '0;
    end else begin
      state    <= state_n;
      sec      <= sec_n;
      word     <= word_n;
      byte_idx <= byte_n;
      start_d  <= start;
      if (state == ST_CAPTURE) word_buf <= sec_word;
      // Address is loaded together with the read strobe, then held
      if (state_n == ST_ISSUE) begin
        unique case (sec_n)
          SEC_C0:  C0_addr <= word_n[AW-1:0];
          SEC_C1:  C1_addr <= word_n[2:0];
          default: K_addr  <= word_n[2:0];
        endcase
      end
    end
  end

  always_comb begin
    unique case (sec)
      SEC_C0:  sec_word = C0_out;
      SEC_C1:  sec_word = C1_out;
      default: sec_word = K_out;
    endcase
    last_word = (sec == SEC_C0) ? C0_LAST : SK_LAST;
    unique case (byte_idx)
      2'd0:    tx_byte = word_buf[31:24];
      2'd1:    tx_byte = word_buf[23:16];
      2'd2:    tx_byte = word_buf[15:8];
      default: tx_byte = word_buf[7:0];
    endcase
  end

  always_comb begin
    state_n  = state;
    sec_n    = sec;
    word_n   = word;
    byte_n   = byte_idx;
    tx_start = 1'b0;
    rd_C0    = 1'b0;
    rd_C1    = 1'b0;
    rd_K     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && !start_d) begin
          state_n = ST_ISSUE;
          sec_n   = SEC_C0;
          word_n  = '0;
        end
      end
      ST_ISSUE: begin
        unique case (sec)
          SEC_C0:  rd_C0 = 1'b1;
          SEC_C1:  rd_C1 = 1'b1;
          default: rd_K  = 1'b1;
        endcase
        state_n = ST_WAIT;
      end
      ST_WAIT:    state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        byte_n  = '0;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        tx_start = 1'b1;
        state_n  = ST_XMIT;
      end
      ST_XMIT: if (tx_done) state_n = ST_NEXT;
      ST_NEXT: begin
        if (byte_idx != 2'd3) begin
          byte_n  = byte_idx + 2'd1;
          state_n = ST_SEND;
        end else if (word != last_word) begin
          word_n  = word + WW'(1);
          state_n = ST_ISSUE;
        end else if (sec == SEC_K) begin
          state_n = ST_FIN;
        end else begin
          sec_n   = (sec == SEC_C0) ? SEC_C1 : SEC_K;
          word_n  = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  uart_tx_byte u_tx (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .tx_start(tx_start),
    .din     (tx_byte),
    .tx      (o_uart_tx),
    .tx_done (tx_done)
  );

endmodule
